// File: rtl/hist_peak_finder.sv
// Scans a finished histogram bank pixel by pixel over a synchronous read port
// and reports each pixel's maximum-count bin over a valid/ready handshake.
module hist_peak_finder #(
  parameter int NB        = 6,
  parameter int PIXEL_NUM = 200,
  parameter int CNT_W     = 16,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              bank,
  input  logic [CNT_W-1:0]  thresh,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              pk_valid,
  input  logic              pk_ready,
  output logic [PIX_W-1:0]  pk_pixel,
  output logic [NB-1:0]     pk_bin,
  output logic [CNT_W-1:0]  pk_count,
  output logic              pk_hit,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, LAST, OUT} state_t;

  localparam logic [NB-1:0]     BIN_LAST = '1;
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIXEL_NUM - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(2**NB);

  state_t             state, state_d;
  logic [PIX_W-1:0]   pixel;
  logic [ADDR_W-1:0]  base;
  logic [NB-1:0]      bin;
  logic [CNT_W-1:0]   thresh_q;

  logic               vld_p1;
  logic [NB-1:0]      bin_p1;
  logic [CNT_W-1:0]   max_count;
  logic [NB-1:0]      max_bin;

  logic               take;
  logic [CNT_W-1:0]   cand_count;
  logic [NB-1:0]      cand_bin;

  function automatic logic is_hit(input logic [CNT_W-1:0] c,
                                  input logic [CNT_W-1:0] t);
    return (c >= t) && (c != '0);
  endfunction

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = READ;
      READ:    if (bin == BIN_LAST) state_d = LAST;
      LAST:    state_d = OUT;
      OUT:     if (pk_ready) state_d = (pixel == PIX_LAST) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Compare stage p1: first bin of a pixel loads unconditionally, ties keep the lower bin
  always_comb begin
    take       = vld_p1 && ((bin_p1 == '0) || (rd_data > max_count));
    cand_count = take ? rd_data : max_count;
    cand_bin   = take ? bin_p1  : max_bin;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      rd_en    <= 1'b0;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
      pixel    <= '0;
      base     <= '0;
      bin      <= '0;
      vld_p1   <= 1'b0;
      pk_valid <= 1'b0;
      pk_pixel <= '0;
      pk_bin   <= '0;
      pk_count <= '0;
      pk_hit   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state  <= state_d;
      busy   <= (state_d != IDLE);
      done   <= 1'b0;
      vld_p1 <= rd_en;
      if (start && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            rd_bank <= bank;
            pixel   <= '0;
            base    <= '0;
            bin     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
          end
        end
        READ: begin
          if (bin == BIN_LAST) begin
            rd_en <= 1'b0;
          end else begin
            bin     <= bin + NB'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        LAST: begin
          pk_valid <= 1'b1;
          pk_pixel <= pixel;
          pk_bin   <= cand_bin;
          pk_count <= cand_count;
          pk_hit   <= is_hit(cand_count, thresh_q);
        end
        OUT: begin
          if (pk_ready) begin
            pk_valid <= 1'b0;
            if (pixel == PIX_LAST) begin
              done <= 1'b1;
            end else begin
              pixel   <= pixel + PIX_W'(1);
              base    <= base + STRIDE;
              rd_addr <= base + STRIDE;
              bin     <= '0;
              rd_en   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read-issue stage p0 -> compare stage p1 datapath registers
  always_ff @(posedge clk) begin
    bin_p1 <= bin;
    if ((state == IDLE) && start) thresh_q <= thresh;
    if (take) begin
      max_count <= rd_data;
      max_bin   <= bin_p1;
    end
  end

endmodule
